// File: rtl/psum_gather_serializer_pkg.sv
// Shared types and helpers for the psum gather serializer.
package psum_gather_pkg;

  typedef enum int {
    ARB_FIXED = 0,
    ARB_RR    = 1
  } arb_mode_e;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } ser_state_e;

  localparam int PSUM_W_DEFAULT = 40;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/psum_gather_serializer_if.sv
// Serial psum beat bus towards the interconnect.
interface psum_gather_serializer_if #(
  parameter int PSUM_W = 40,
  parameter int ROW_W  = 2,
  parameter int COL_W  = 2
);

  logic [PSUM_W-1:0] icm_psum_writedata_o;
  logic [ROW_W-1:0]  icm_psum_row_o;
  logic [COL_W-1:0]  icm_psum_col_o;
  logic              icm_psum_last_o;
  logic              icm_psum_cs_o;
  logic              icm_psum_waitreq_i;

  modport master (
    output icm_psum_writedata_o,
    output icm_psum_row_o,
    output icm_psum_col_o,
    output icm_psum_last_o,
    output icm_psum_cs_o,
    input  icm_psum_waitreq_i
  );

  modport slave (
    input  icm_psum_writedata_o,
    input  icm_psum_row_o,
    input  icm_psum_col_o,
    input  icm_psum_last_o,
    input  icm_psum_cs_o,
    output icm_psum_waitreq_i
  );

endinterface

// File: rtl/psum_gather_serializer_arbiter.sv
// Row arbiter: round robin from last_grant+1, or highest index wins.
module psum_rr_arbiter
  import psum_gather_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MODE    = ARB_RR,
  localparam int IDX_W  = idx_w(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] last_grant_q;
  logic [IDX_W-1:0] last_grant_d;
  logic             found;
  int unsigned      k;

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    k         = 0;
    if (MODE == ARB_RR) begin
      for (int i = 1; i <= NUM_REQ; i++) begin
        k = (int'(last_grant_q) + i) % NUM_REQ;
        if (!found && req[IDX_W'(k)]) begin
          found     = 1'b1;
          grant_idx = IDX_W'(k);
        end
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req[i]) begin
          found     = 1'b1;
          grant_idx = IDX_W'(i);
        end
      end
    end
    grant_oh = found ? (NUM_REQ'(1) << grant_idx) : '0;
  end

  always_comb begin
    last_grant_d = advance ? grant_idx : last_grant_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/psum_gather_serializer.sv
// Gathers one granted psum row and streams its enabled words as beats.
module psum_gather_serializer
  import psum_gather_pkg::*;
#(
  parameter int NUM_ROWS = 4,
  parameter int NUM_COLS = 4,
  parameter int PSUM_W   = PSUM_W_DEFAULT,
  parameter int ARB_MODE = 1,
  localparam int ROW_W   = idx_w(NUM_ROWS),
  localparam int COL_W   = idx_w(NUM_COLS)
) (
  input  logic clock,
  input  logic reset,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0][PSUM_W-1:0] row_psum_writedata_i,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0] row_psum_wordenable_i,
  input  logic [NUM_ROWS-1:0] row_psum_cs_i,
  output logic [NUM_ROWS-1:0] row_psum_waitreq_o,
  psum_gather_serializer_if.master icm
);

  typedef logic [NUM_COLS-1:0][PSUM_W-1:0] row_data_t;
  typedef logic [NUM_COLS-1:0] mask_t;

  ser_state_e        state_q, state_d;
  row_data_t         data_q, data_d;
  mask_t             mask_q, mask_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [PSUM_W-1:0] wdata_q, wdata_d;
  logic              last_q, last_d;

  logic [NUM_ROWS-1:0] grant_oh;
  logic [ROW_W-1:0]    grant_idx;
  logic                can_accept;
  logic                accept;
  logic                beat_done;
  row_data_t           sel_data;
  mask_t               sel_mask;

  function automatic logic [COL_W-1:0] low_idx(input mask_t m);
    low_idx = '0;
    for (int i = NUM_COLS - 1; i >= 0; i--)
      if (m[i]) low_idx = COL_W'(i);
  endfunction

  function automatic logic [PSUM_W-1:0] pick_word(
    input row_data_t d,
    input mask_t     m
  );
    pick_word = '0;
    for (int i = NUM_COLS - 1; i >= 0; i--)
      if (m[i]) pick_word = d[i];
  endfunction

  psum_rr_arbiter #(
    .NUM_REQ (NUM_ROWS),
    .MODE    (ARB_MODE)
  ) u_arb (
    .clock     (clock),
    .reset     (reset),
    .req       (row_psum_cs_i),
    .advance   (accept),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx)
  );

  always_comb begin
    sel_data = '0;
    sel_mask = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (grant_oh[r]) begin
        sel_data = row_psum_writedata_i[r];
        sel_mask = row_psum_wordenable_i[r];
      end
    end
  end

  // A row may land in the same cycle the final beat leaves.
  assign beat_done  = (state_q == ST_SEND) && !icm.icm_psum_waitreq_i;
  assign can_accept = (state_q == ST_IDLE) || (last_q && beat_done);
  assign accept     = (|grant_oh) && can_accept;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mask_d  = mask_q;
    row_d   = row_q;
    col_d   = col_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    if (beat_done) begin
      if (last_q) begin
        state_d = ST_IDLE;
        last_d  = 1'b0;
      end else begin
        col_d   = low_idx(mask_q);
        wdata_d = pick_word(data_q, mask_q);
        mask_d  = mask_q & (mask_q - mask_t'(1));
        last_d  = (mask_d == '0);
      end
    end
    if (accept && (sel_mask != '0)) begin
      state_d = ST_SEND;
      data_d  = sel_data;
      row_d   = grant_idx;
      col_d   = low_idx(sel_mask);
      wdata_d = pick_word(sel_data, sel_mask);
      mask_d  = sel_mask & (sel_mask - mask_t'(1));
      last_d  = (mask_d == '0);
    end
  end

  always_comb begin
    icm.icm_psum_cs_o        = (state_q == ST_SEND);
    icm.icm_psum_writedata_o = wdata_q;
    icm.icm_psum_row_o       = row_q;
    icm.icm_psum_col_o       = col_q;
    icm.icm_psum_last_o      = last_q;
    row_psum_waitreq_o       = ~(grant_oh & {NUM_ROWS{can_accept}});
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      mask_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      wdata_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      row_q   <= row_d;
      col_q   <= col_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_psum_gather_serializer.sv
// Bench for psum_gather_serializer: RR, fixed and 1x8 instances.
module tb_psum_gather_serializer;

  localparam int NR  = 4;
  localparam int NC  = 4;
  localparam int W   = 40;
  localparam int NC2 = 8;
  localparam int W2  = 16;

  typedef struct packed {
    logic [1:0]   row;
    logic [1:0]   col;
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  logic [NR-1:0][NC-1:0][W-1:0] a_data;
  logic [NR-1:0][NC-1:0]        a_en;
  logic [NR-1:0]                a_cs, a_wr;
  logic [NR-1:0][NC-1:0][W-1:0] b_data;
  logic [NR-1:0][NC-1:0]        b_en;
  logic [NR-1:0]                b_cs, b_wr;
  logic [0:0][NC2-1:0][W2-1:0]  c_data;
  logic [0:0][NC2-1:0]          c_en;
  logic [0:0]                   c_cs, c_wr;

  psum_gather_serializer_if #(.PSUM_W(W), .ROW_W(2), .COL_W(2)) a_if ();
  psum_gather_serializer_if #(.PSUM_W(W), .ROW_W(2), .COL_W(2)) b_if ();
  psum_gather_serializer_if #(.PSUM_W(W2), .ROW_W(1), .COL_W(3)) c_if ();

  psum_gather_serializer #(
    .NUM_ROWS(NR), .NUM_COLS(NC), .PSUM_W(W), .ARB_MODE(1)
  ) dut_rr (
    .clock(clock), .reset(reset),
    .row_psum_writedata_i(a_data), .row_psum_wordenable_i(a_en),
    .row_psum_cs_i(a_cs), .row_psum_waitreq_o(a_wr), .icm(a_if)
  );

  psum_gather_serializer #(
    .NUM_ROWS(NR), .NUM_COLS(NC), .PSUM_W(W), .ARB_MODE(0)
  ) dut_fx (
    .clock(clock), .reset(reset),
    .row_psum_writedata_i(b_data), .row_psum_wordenable_i(b_en),
    .row_psum_cs_i(b_cs), .row_psum_waitreq_o(b_wr), .icm(b_if)
  );

  psum_gather_serializer #(
    .NUM_ROWS(1), .NUM_COLS(NC2), .PSUM_W(W2), .ARB_MODE(1)
  ) dut_w (
    .clock(clock), .reset(reset),
    .row_psum_writedata_i(c_data), .row_psum_wordenable_i(c_en),
    .row_psum_cs_i(c_cs), .row_psum_waitreq_o(c_wr), .icm(c_if)
  );

  function automatic logic [W-1:0] rand_word();
    return W'({$urandom(), $urandom()});
  endfunction

  function automatic int rr_pick(input int last, input logic [NR-1:0] req);
    for (int i = 1; i <= NR; i++)
      if (req[(last + i) % NR]) return (last + i) % NR;
    return 0;
  endfunction

  task automatic clear_inputs();
    a_data = '0; a_en = '0; a_cs = '0;
    b_data = '0; b_en = '0; b_cs = '0;
    c_data = '0; c_en = '0; c_cs = '0;
    a_if.icm_psum_waitreq_i = 1'b0;
    b_if.icm_psum_waitreq_i = 1'b0;
    c_if.icm_psum_waitreq_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    clear_inputs();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    clear_inputs();
    reset = 1'b1;
    #1;
    n_checks++;
    if (a_if.icm_psum_cs_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_cs: got %b want 0", a_if.icm_psum_cs_o);
    end
    n_checks++;
    if (a_if.icm_psum_writedata_o !== '0) begin
      n_fail++; $display("FAIL rst_data: got %h want 0", a_if.icm_psum_writedata_o);
    end
    n_checks++;
    if ({a_if.icm_psum_row_o, a_if.icm_psum_col_o, a_if.icm_psum_last_o} !== 5'b0) begin
      n_fail++; $display("FAIL rst_rcl: got %b want 0",
        {a_if.icm_psum_row_o, a_if.icm_psum_col_o, a_if.icm_psum_last_o});
    end
    n_checks++;
    if (a_wr !== 4'b1111) begin
      n_fail++; $display("FAIL rst_waitreq: got %b want 1111", a_wr);
    end
    n_checks++;
    if (c_if.icm_psum_cs_o !== 1'b0 || c_wr !== 1'b1) begin
      n_fail++; $display("FAIL rst_wide: cs %b wr %b want 0 1", c_if.icm_psum_cs_o, c_wr);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_row();
    logic [W-1:0] wa, wb, wc, wd;
    wa = rand_word(); wb = rand_word(); wc = rand_word(); wd = rand_word();
    do_reset();
    @(negedge clock);
    a_cs[0] = 1'b1; a_en[0] = 4'b1011; a_data[0] = {wa, wb, wc, wd};
    #1;
    n_checks++;
    if (a_wr !== 4'b1110) begin
      n_fail++; $display("FAIL mid_accept: got %b want 1110", a_wr);
    end
    @(negedge clock);
    a_cs = '0;
    #1;
    n_checks++;
    if ({a_if.icm_psum_cs_o, a_if.icm_psum_col_o, a_if.icm_psum_last_o,
         a_if.icm_psum_writedata_o} !== {1'b1, 2'd0, 1'b0, wd}) begin
      n_fail++; $display("FAIL mid_beat0: got col %0d last %b data %h want 0 0 %h",
        a_if.icm_psum_col_o, a_if.icm_psum_last_o, a_if.icm_psum_writedata_o, wd);
    end
    @(negedge clock);
    #1;
    n_checks++;
    if ({a_if.icm_psum_cs_o, a_if.icm_psum_col_o, a_if.icm_psum_last_o,
         a_if.icm_psum_writedata_o} !== {1'b1, 2'd1, 1'b0, wc}) begin
      n_fail++; $display("FAIL mid_beat1: got col %0d last %b data %h want 1 0 %h",
        a_if.icm_psum_col_o, a_if.icm_psum_last_o, a_if.icm_psum_writedata_o, wc);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (a_if.icm_psum_cs_o !== 1'b0 || a_wr !== 4'b1111) begin
      n_fail++; $display("FAIL mid_reset: cs %b wr %b want 0 1111", a_if.icm_psum_cs_o, a_wr);
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      #1;
      n_checks++;
      if (a_if.icm_psum_cs_o !== 1'b0) begin
        n_fail++; $display("FAIL mid_no_tail: cs %b want 0", a_if.icm_psum_cs_o);
      end
    end
  endtask

  task automatic test_rr_all();
    int g;
    int pg;
    logic [NR-1:0] exp_wr;
    do_reset();
    pg = -1;
    for (int cyc = 0; cyc < 9; cyc++) begin
      @(negedge clock);
      if (cyc == 0) begin
        a_cs = '1;
        for (int r = 0; r < NR; r++) begin
          a_en[r] = 4'b0001; a_data[r][0] = rand_word();
        end
      end
      #1;
      g = cyc % NR;
      exp_wr = '1; exp_wr[g] = 1'b0;
      n_checks++;
      if (a_wr !== exp_wr) begin
        n_fail++; $display("FAIL rr_grant: got %b want %b", a_wr, exp_wr);
      end
      if (pg >= 0) begin
        n_checks++;
        if ({a_if.icm_psum_cs_o, a_if.icm_psum_row_o, a_if.icm_psum_col_o,
             a_if.icm_psum_last_o, a_if.icm_psum_writedata_o}
            !== {1'b1, 2'(pg), 2'd0, 1'b1, a_data[pg][0]}) begin
          n_fail++; $display("FAIL rr_beat: cs %b row %0d last %b want 1 %0d 1",
            a_if.icm_psum_cs_o, a_if.icm_psum_row_o, a_if.icm_psum_last_o, pg);
        end
      end
      pg = g;
    end
  endtask

  task automatic test_fixed();
    do_reset();
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clock);
      if (cyc == 0) begin
        b_cs = '1;
        for (int r = 0; r < NR; r++) begin
          b_en[r] = 4'b0001; b_data[r][0] = rand_word();
        end
      end
      #1;
      n_checks++;
      if (b_wr !== 4'b0111) begin
        n_fail++; $display("FAIL fx_grant: got %b want 0111", b_wr);
      end
      if (cyc > 0) begin
        n_checks++;
        if ({b_if.icm_psum_cs_o, b_if.icm_psum_row_o, b_if.icm_psum_last_o,
             b_if.icm_psum_writedata_o} !== {1'b1, 2'd3, 1'b1, b_data[3][0]}) begin
          n_fail++; $display("FAIL fx_beat: cs %b row %0d last %b want 1 3 1",
            b_if.icm_psum_cs_o, b_if.icm_psum_row_o, b_if.icm_psum_last_o);
        end
      end
    end
  endtask

  task automatic test_stall();
    beat_t want;
    beat_t got;
    do_reset();
    @(negedge clock);
    a_cs[2] = 1'b1; a_en[2] = 4'b0110;
    for (int c = 0; c < NC; c++) a_data[2][c] = rand_word();
    #1;
    n_checks++;
    if (a_wr !== 4'b1011) begin
      n_fail++; $display("FAIL st_accept: got %b want 1011", a_wr);
    end
    @(negedge clock);
    a_cs[2] = 1'b0;
    a_cs[0] = 1'b1; a_en[0] = 4'b0001; a_data[0][0] = rand_word();
    a_if.icm_psum_waitreq_i = 1'b1;
    want = '{row: 2'd2, col: 2'd1, data: a_data[2][1], last: 1'b0};
    for (int i = 0; i < 4; i++) begin
      if (i == 3) a_if.icm_psum_waitreq_i = 1'b0;
      #1;
      got = '{row: a_if.icm_psum_row_o, col: a_if.icm_psum_col_o,
              data: a_if.icm_psum_writedata_o, last: a_if.icm_psum_last_o};
      n_checks++;
      if (a_if.icm_psum_cs_o !== 1'b1 || got !== want) begin
        n_fail++; $display("FAIL st_hold: cs %b got %h want %h", a_if.icm_psum_cs_o, got, want);
      end
      n_checks++;
      if (a_wr !== 4'b1111) begin
        n_fail++; $display("FAIL st_block: got %b want 1111", a_wr);
      end
      @(negedge clock);
    end
    a_if.icm_psum_waitreq_i = 1'b1;
    want = '{row: 2'd2, col: 2'd2, data: a_data[2][2], last: 1'b1};
    for (int i = 0; i < 2; i++) begin
      if (i == 1) a_if.icm_psum_waitreq_i = 1'b0;
      #1;
      got = '{row: a_if.icm_psum_row_o, col: a_if.icm_psum_col_o,
              data: a_if.icm_psum_writedata_o, last: a_if.icm_psum_last_o};
      n_checks++;
      if (a_if.icm_psum_cs_o !== 1'b1 || got !== want) begin
        n_fail++; $display("FAIL st_last: cs %b got %h want %h", a_if.icm_psum_cs_o, got, want);
      end
      n_checks++;
      if (a_wr !== ((i == 1) ? 4'b1110 : 4'b1111)) begin
        n_fail++; $display("FAIL st_last_wr: got %b at step %0d", a_wr, i);
      end
      @(negedge clock);
    end
    a_cs[0] = 1'b0;
    #1;
    n_checks++;
    if ({a_if.icm_psum_cs_o, a_if.icm_psum_row_o, a_if.icm_psum_last_o,
         a_if.icm_psum_writedata_o} !== {1'b1, 2'd0, 1'b1, a_data[0][0]}) begin
      n_fail++; $display("FAIL st_next: cs %b row %0d last %b want 1 0 1",
        a_if.icm_psum_cs_o, a_if.icm_psum_row_o, a_if.icm_psum_last_o);
    end
  endtask

  task automatic test_zero_mask();
    do_reset();
    @(negedge clock);
    a_cs[1] = 1'b1; a_en[1] = 4'b0000;
    #1;
    n_checks++;
    if (a_wr !== 4'b1101) begin
      n_fail++; $display("FAIL zm_accept: got %b want 1101", a_wr);
    end
    @(negedge clock);
    a_cs[2] = 1'b1; a_en[2] = 4'b1000; a_data[2][3] = rand_word();
    #1;
    n_checks++;
    if (a_if.icm_psum_cs_o !== 1'b0) begin
      n_fail++; $display("FAIL zm_nobeat: cs %b want 0", a_if.icm_psum_cs_o);
    end
    n_checks++;
    if (a_wr !== 4'b1011) begin
      n_fail++; $display("FAIL zm_rr: got %b want 1011", a_wr);
    end
    @(negedge clock);
    a_cs = '0;
    #1;
    n_checks++;
    if ({a_if.icm_psum_cs_o, a_if.icm_psum_row_o, a_if.icm_psum_col_o,
         a_if.icm_psum_last_o, a_if.icm_psum_writedata_o}
        !== {1'b1, 2'd2, 2'd3, 1'b1, a_data[2][3]}) begin
      n_fail++; $display("FAIL zm_beat: cs %b row %0d col %0d last %b want 1 2 3 1",
        a_if.icm_psum_cs_o, a_if.icm_psum_row_o, a_if.icm_psum_col_o, a_if.icm_psum_last_o);
    end
  endtask

  task automatic test_wide();
    do_reset();
    @(negedge clock);
    c_cs = 1'b1; c_en[0] = 8'hFF;
    for (int c = 0; c < NC2; c++) c_data[0][c] = W2'($urandom());
    #1;
    n_checks++;
    if (c_wr !== 1'b0) begin
      n_fail++; $display("FAIL w_accept: got %b want 0", c_wr);
    end
    @(negedge clock);
    c_cs = 1'b0;
    for (int c = 0; c <= NC2; c++) begin
      #1;
      n_checks++;
      if (c == NC2) begin
        if (c_if.icm_psum_cs_o !== 1'b0) begin
          n_fail++; $display("FAIL w_end: cs %b want 0", c_if.icm_psum_cs_o);
        end
      end else if ({c_if.icm_psum_cs_o, c_if.icm_psum_row_o, c_if.icm_psum_col_o,
                    c_if.icm_psum_last_o, c_if.icm_psum_writedata_o}
                   !== {1'b1, 1'b0, 3'(c), (c == NC2 - 1), c_data[0][c]}) begin
        n_fail++; $display("FAIL w_beat: cs %b col %0d last %b want col %0d",
          c_if.icm_psum_cs_o, c_if.icm_psum_col_o, c_if.icm_psum_last_o, c);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_random();
    beat_t exp_q[$];
    beat_t got, held, cur, b;
    bit held_v;
    int last_g, g, nb;
    logic [NR-1:0] drop, exp_wr;
    held_v = 1'b0; last_g = NR - 1; drop = '0;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clock);
      a_cs = a_cs & ~drop;
      drop = '0;
      for (int r = 0; r < NR; r++) begin
        if (!a_cs[r] && $urandom_range(0, 2) == 0) begin
          a_cs[r] = 1'b1;
          a_en[r] = NC'($urandom());
          for (int c = 0; c < NC; c++) a_data[r][c] = rand_word();
        end
      end
      a_if.icm_psum_waitreq_i = ($urandom_range(0, 3) == 0);
      #1;
      n_checks++;
      if (a_if.icm_psum_cs_o !== (exp_q.size() != 0)) begin
        n_fail++; $display("FAIL rnd_cs: got %b pending %0d", a_if.icm_psum_cs_o, exp_q.size());
      end
      got = '{row: a_if.icm_psum_row_o, col: a_if.icm_psum_col_o,
              data: a_if.icm_psum_writedata_o, last: a_if.icm_psum_last_o};
      if (a_if.icm_psum_cs_o === 1'b1 && exp_q.size() != 0) begin
        if (held_v) begin
          n_checks++;
          if (got !== held) begin
            n_fail++; $display("FAIL rnd_hold: got %h want %h", got, held);
          end
        end
        if (!a_if.icm_psum_waitreq_i) begin
          cur = exp_q.pop_front();
          held_v = 1'b0;
          n_checks++;
          if (got !== cur) begin
            n_fail++; $display("FAIL rnd_beat: got %h want %h", got, cur);
          end
        end else begin
          held = got; held_v = 1'b1;
        end
      end else begin
        held_v = 1'b0;
      end
      exp_wr = '1;
      g = -1;
      if (exp_q.size() == 0 && a_cs != '0) begin
        g = rr_pick(last_g, a_cs);
        exp_wr[g] = 1'b0;
      end
      n_checks++;
      if (a_wr !== exp_wr) begin
        n_fail++; $display("FAIL rnd_waitreq: got %b want %b", a_wr, exp_wr);
      end
      if (g >= 0) begin
        nb = 0;
        for (int c = 0; c < NC; c++) begin
          if (a_en[g][c]) begin
            b = '{row: 2'(g), col: 2'(c), data: a_data[g][c], last: 1'b0};
            exp_q.push_back(b);
            nb++;
          end
        end
        if (nb > 0) exp_q[exp_q.size() - 1].last = 1'b1;
        drop[g] = 1'b1;
        last_g = g;
      end
    end
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clock);
      a_cs = '0;
      a_if.icm_psum_waitreq_i = 1'b0;
      #1;
      if (exp_q.size() != 0) begin
        cur = exp_q.pop_front();
        got = '{row: a_if.icm_psum_row_o, col: a_if.icm_psum_col_o,
                data: a_if.icm_psum_writedata_o, last: a_if.icm_psum_last_o};
        n_checks++;
        if (a_if.icm_psum_cs_o !== 1'b1 || got !== cur) begin
          n_fail++; $display("FAIL rnd_drain: cs %b got %h want %h", a_if.icm_psum_cs_o, got, cur);
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0 || a_if.icm_psum_cs_o !== 1'b0) begin
      n_fail++; $display("FAIL rnd_empty: left %0d cs %b want 0 0", exp_q.size(), a_if.icm_psum_cs_o);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_reset_mid_row();
    test_rr_all();
    test_fixed();
    test_stall();
    test_zero_mask();
    test_wide();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/psum_gather_serializer.md
# psum_gather_serializer

Parametrised partial-sum gather block between the PU row array and the psum interconnect master port. It arbitrates among `NUM_ROWS` row requesters, each offering one row of `NUM_COLS` psum words with a word-enable mask. It latches the granted row and serialises its enabled words onto a single `PSUM_W`-bit write-only master, tagging each beat with row/column index and a last flag. Compared with the existing fixed-priority collector, it adds selectable round-robin arbitration, full backpressure on the output, and zero-bubble row-to-row transfers.

## Interface
- `NUM_ROWS`, 4, number of row requesters (≥1)
- `NUM_COLS`, 4, psum words per row (≥1)
- `PSUM_W`, 40, psum word width
- `ARB_MODE`, 1, 0 = fixed priority (highest row index wins), 1 = round robin
- `clock`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `row_psum_writedata_i`  in  `[NUM_ROWS][NUM_COLS]` × `PSUM_W`  per-row psum words
- `row_psum_wordenable_i`  in  `[NUM_ROWS]` × `NUM_COLS`  valid-word mask per row
- `row_psum_cs_i`  in  `NUM_ROWS`  row request
- `row_psum_waitreq_o`  out  `NUM_ROWS`  per-row stall; transfer = cs & !waitreq
- `icm_psum_writedata_o`  out  `PSUM_W`  serial psum word
- `icm_psum_row_o`  out  `max(1,$clog2(NUM_ROWS))`  source row of beat
- `icm_psum_col_o`  out  `max(1,$clog2(NUM_COLS))`  source column of beat
- `icm_psum_last_o`  out  1  final enabled word of the row
- `icm_psum_cs_o`  out  1  beat valid
- `icm_psum_waitreq_i`  in  1  downstream stall

## Operation
- Row handshake: a row holds cs, data and mask stable while its waitreq is 1. The row is accepted in the cycle cs=1 & waitreq=0. At most one row waitreq is 0 per cycle, and only the granted one.
- Holding register: data[`NUM_COLS`], remaining mask, row index, `busy`.
- `can_accept` = !busy, or (beat on the output is last & !icm_psum_waitreq_i). The granted row's waitreq = !can_accept. All other rows have waitreq = 1.
- Arbiter (ARB_MODE=1): search starts at `last_grant+1` modulo `NUM_ROWS`. `last_grant` updates only on acceptance. Reset value is `NUM_ROWS-1`, so row 0 has first priority.
- ARB_MODE=0: the highest-indexed requesting row wins.
- Serialiser states:
  - IDLE: busy=0.
  - SEND: the output shows the lowest set bit of the remaining mask. When `!icm_psum_waitreq_i`, clear that bit. If it was the last bit, go to IDLE, or reload directly from a same-cycle acceptance.
- Mask all-zero on acceptance: the row is consumed, no beats are emitted, and the block stays in or returns to IDLE. `last_grant` still updates.
- Output beats are registered. cs, data, row, col and last stay stable while `icm_psum_waitreq_i`=1.
- Widths: no arithmetic on data. Indices are zero-extended when `NUM_ROWS` or `NUM_COLS`=1.

## Timing
- Reset, asynchronous:
  - `icm_psum_cs_o`=0, `icm_psum_writedata_o`=0, row=0, col=0, last=0.
  - Holding mask=0, busy=0.
  - `row_psum_waitreq_o` is all 1s (IDLE with no requests forces all to 1).
  - `last_grant`=`NUM_ROWS-1`.
- Reset mid-row discards the in-flight row and emits no partial last.
- Latency: acceptance at cycle k puts the first beat on the output at k+1 (cs=1).
- Throughput: one beat per cycle without stall. A row with N enabled words occupies N cycles.
- Back-to-back rows: a row accepted on the last-beat cycle has its first beat at the next cycle, with no bubble.
- Stall on the last beat: can_accept=0, so every row waitreq stays 1.
- Simultaneous requests from all rows in RR mode: grants rotate 0,1,2,3,0…

## Structure
- Package `psum_gather_pkg`:
  - `arb_mode_e` {ARB_FIXED, ARB_RR}
  - `PSUM_W_DEFAULT`=40
  - `idx_w(n)` function returning `max(1,$clog2(n))`
- Sub-module `psum_rr_arbiter` (params: `NUM_REQ`, `MODE`):
  - inputs: req, advance
  - outputs: grant one-hot, grant index
  - holds `last_grant`
- The serialiser FSM and holding register stay in the top module.

## Test plan
- Reset mid-row:
  - Row 0 mask 4'b1011, data {A,B,C,D} (col0..3), no stall → beats D(c0), C(c1), A(c3, last=1) on cycles k+1..k+3.
  - Reset at k+2 → cs=0 immediately, all waitreq=1.
- All four rows requesting continuously, masks 4'b0001, RR → grants 0,1,2,3,0. One beat per cycle, last=1 on every beat, no bubbles.
- Same stimulus, ARB_MODE=0 → row 3 is granted repeatedly. Rows 0-2 have waitreq=1 throughout.
- Row 2 mask 4'b0110, `icm_psum_waitreq_i` high for 3 cycles on the first beat → beat is held stable; the next row is not accepted until the last beat completes.
- Row 1 mask 4'b0000, then row 2 mask 4'b1000 → row 1 is accepted with no beat. Row 2's single beat has col=3, last=1.
- `NUM_ROWS`=1, `NUM_COLS`=8, `PSUM_W`=16, mask 8'hFF → 8 beats, col 0..7, last only on col 7.
